// File: rtl/sw_host_driver.sv
// -----------------------------------------------------------------------------
// sw_host_driver
//
// Host-side sequencer for a Smith-Waterman alignment core. The host loads
// N_BYTES query/database byte pairs into a small buffer, then requests a run
// with go. The driver waits for the core to be ready, pulses start, streams
// the buffered bytes one per cycle, and waits (bounded by TIMEOUT cycles)
// for the core's result strobe. The captured result is presented to the host
// with a one-cycle res_valid. A run that times out sets the sticky
// timeout_err flag instead.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ld_valid, ld_query, ld_db       host byte-pair load (ld_ready handshake)
//   ld_ready                        buffer can take a byte pair
//   go                              host launch request
//   start                           one-cycle start strobe to the core
//   query_seq_in, database_seq_in   streamed bytes to the core (0 when idle)
//   ready                           core is idle and can accept start
//   output_valid, score,
//   query_seq_out, database_seq_out core result strobe and payload
//   res_valid                       one-cycle result strobe to the host
//   res_score, res_q_end, res_d_end registered result
//   busy                            high in every state except IDLE
//   timeout_err                     sticky abort flag, cleared by next go
// -----------------------------------------------------------------------------
module sw_host_driver #(
    parameter int N_BYTES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_valid,
    input  logic [7:0] ld_query,
    input  logic [7:0] ld_db,
    output logic       ld_ready,
    input  logic       go,
    output logic       start,
    output logic [7:0] query_seq_in,
    output logic [7:0] database_seq_in,
    input  logic       ready,
    input  logic       output_valid,
    input  logic [6:0] score,
    input  logic [2:0] query_seq_out,
    input  logic [2:0] database_seq_out,
    output logic       res_valid,
    output logic [6:0] res_score,
    output logic [2:0] res_q_end,
    output logic [2:0] res_d_end,
    output logic       busy,
    output logic       timeout_err
);

    // Buffer index width (at least 1 bit) and write pointer width (must hold
    // N_BYTES itself, which marks the buffer as full).
    localparam int IW  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int WPW = $clog2(N_BYTES + 1);

    localparam logic [WPW-1:0] WP_FULL = WPW'(N_BYTES);
    localparam logic [IW-1:0]  RP_LAST = IW'(N_BYTES - 1);
    localparam logic [7:0]     CNT_MAX = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        STREAM,
        WAIT_RES,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [7:0]     q_buf [N_BYTES];
    logic [7:0]     d_buf [N_BYTES];
    logic [WPW-1:0] wp;
    logic [IW-1:0]  rp;
    logic [7:0]     cnt;
    logic           captured;   // a result was captured during this run

    logic           load;
    logic           go_accept;

    assign ld_ready  = (state == IDLE) && (wp < WP_FULL);
    assign load      = ld_valid && ld_ready;
    // go with a partially filled buffer is silently dropped.
    assign go_accept = (state == IDLE) && go && (wp == WP_FULL);
    assign busy      = (state != IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        start           = 1'b0;
        res_valid       = 1'b0;
        query_seq_in    = 8'h00;
        database_seq_in = 8'h00;

        case (state)
            IDLE: begin
                if (go_accept) state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready) state_next = START;
            end
            START: begin
                start      = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                query_seq_in    = q_buf[rp];
                database_seq_in = d_buf[rp];
                if (rp == RP_LAST) state_next = WAIT_RES;
            end
            WAIT_RES: begin
                if (output_valid || (cnt == CNT_MAX)) state_next = DONE;
            end
            DONE: begin
                res_valid  = captured;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Byte buffer
    // -------------------------------------------------------------------------
    // NOTE: the storage arrays are not reset; contents are only ever read
    // below wp, and wp is reset, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (load) begin
            q_buf[wp[IW-1:0]] <= ld_query;
            d_buf[wp[IW-1:0]] <= ld_db;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, timeout counter, result capture and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp          <= '0;
            rp          <= '0;
            cnt         <= 8'd0;
            captured    <= 1'b0;
            timeout_err <= 1'b0;
            res_score   <= 7'd0;
            res_q_end   <= 3'd0;
            res_d_end   <= 3'd0;
        end else begin
            if (load) wp <= wp + WPW'(1);

            case (state)
                IDLE: begin
                    if (go_accept) begin
                        timeout_err <= 1'b0;
                        captured    <= 1'b0;
                    end
                end
                START: begin
                    rp <= '0;
                end
                STREAM: begin
                    // The counter is armed here so WAIT_RES begins at 0.
                    cnt <= 8'd0;
                    rp  <= (rp == RP_LAST) ? '0 : rp + IW'(1);
                end
                WAIT_RES: begin
                    // A result arriving on the final cycle beats the timeout.
                    if (output_valid) begin
                        res_score <= score;
                        res_q_end <= query_seq_out;
                        res_d_end <= database_seq_out;
                        captured  <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    wp       <= '0;
                    captured <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
